// File: rtl/cbu_modn_counter.sv
// ----------------------------------------------------------------------------
// cbu_modn_counter
//
// Parameterised synchronous up counter. It counts 0 .. MODULUS-1 and then
// wraps to 0. It has cascade carry in/out so that stages can be chained into
// multi-digit counters, such as BCD counters or timebase prescalers.
// It also provides:
//   - a parallel load,
//   - a synchronous clear,
//   - a synchronous preset to the terminal count,
//   - a sticky wrap flag.
//
// Parameters
//   WIDTH    counter width in bits (2..16)
//   MODULUS  sequence length; Q runs 0..MODULUS-1 (2..2**WIDTH)
//
// Ports
//   CLK      rising-edge clock
//   CDN      asynchronous active-low clear; forces Q=0 and OVF=0
//   CS       synchronous clear (highest synchronous priority)
//   SP       synchronous preset to MODULUS-1
//   LD       synchronous parallel load of D (loaded unchanged, even if D is
//            out of range)
//   D        parallel load data
//   EN       count enable, shared by all stages of a cascade
//   CAI      cascade carry in; tie high on the least significant stage
//   OVF_CLR  synchronous clear of OVF. A wrap in the same cycle wins.
//   Q        current count
//   CAO      cascade carry out (combinational): CAI & EN & terminal
//   OVF      sticky wrap flag (registered)
// ----------------------------------------------------------------------------
module cbu_modn_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
) (
   input  logic             CLK,
   input  logic             CDN,
   input  logic             CS,
   input  logic             SP,
   input  logic             LD,
   input  logic [WIDTH-1:0] D,
   input  logic             EN,
   input  logic             CAI,
   input  logic             OVF_CLR,
   output logic [WIDTH-1:0] Q,
   output logic             CAO,
   output logic             OVF
);

   // The terminal value always fits in WIDTH bits, because MODULUS <= 2**WIDTH.
   localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] q_next;
   logic             ovf_reg;
   logic             ovf_next;
   logic             at_term;
   logic             count_go;
   logic             wrap_evt;

   // The test is ">=" rather than "==". This way, an out-of-range value that
   // was loaded through D folds back to 0 on its next count.
   assign at_term  = (q_reg >= TERM);

   // The count branch is taken only when no clear, preset or load request is
   // active.
   assign count_go = ~CS & ~SP & ~LD & CAI & EN;
   assign wrap_evt = count_go & at_term;

   // The carry out deliberately ignores CS, SP and LD.
   // An upper stage therefore sees the same carry that a plain count would
   // produce.
   assign CAO = CAI & EN & at_term;

   always_comb begin
      q_next = q_reg;
      if (CS)
         q_next = '0;
      else if (SP)
         q_next = TERM;
      else if (LD)
         q_next = D;
      else if (count_go)
         q_next = at_term ? '0 : q_reg + 1'b1;
   end

   // Set has priority over clear, so a wrap is never lost to a coincident
   // OVF_CLR.
   always_comb begin
      ovf_next = ovf_reg;
      if (wrap_evt)
         ovf_next = 1'b1;
      else if (OVF_CLR)
         ovf_next = 1'b0;
   end

   always_ff @(posedge CLK or negedge CDN) begin
      if (!CDN) begin
         q_reg   <= '0;
         ovf_reg <= 1'b0;
      end else begin
         q_reg   <= q_next;
         ovf_reg <= ovf_next;
      end
   end

   assign Q   = q_reg;
   assign OVF = ovf_reg;

endmodule

// File: tb/tb_cbu_modn_counter.sv
// ----------------------------------------------------------------------------
// tb_cbu_modn_counter
//
// Directed bench for cbu_modn_counter with WIDTH=4 and MODULUS=10.
//
// Single-stage checks are driven from a vector table:
//   - The inputs of each vector are applied on the falling edge.
//   - CAO is checked before the rising edge.
//   - Q and OVF are checked 1 ns after the rising edge.
//
// Hand-written sequences cover:
//   - the asynchronous clear,
//   - a two-stage decade cascade.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cbu_modn_counter;

   localparam int W = 4;
   localparam int M = 10;

   logic         clk;
   logic         cdn;
   logic         cs, sp, ld, en, cai, ovf_clr;
   logic [W-1:0] d;
   logic [W-1:0] q;
   logic         cao, ovf;

   // Cascade pair
   logic         c_en;
   logic         c_one;
   logic         c_zero;
   logic [W-1:0] c_d;
   logic [W-1:0] lo_q, hi_q;
   logic         lo_cao, hi_cao, lo_ovf, hi_ovf;

   int errors = 0;
   int checks = 0;

   cbu_modn_counter #(.WIDTH(W), .MODULUS(M)) dut (
      .CLK(clk), .CDN(cdn), .CS(cs), .SP(sp), .LD(ld), .D(d), .EN(en),
      .CAI(cai), .OVF_CLR(ovf_clr), .Q(q), .CAO(cao), .OVF(ovf)
   );

   cbu_modn_counter #(.WIDTH(W), .MODULUS(M)) u_lo (
      .CLK(clk), .CDN(cdn), .CS(c_zero), .SP(c_zero), .LD(c_zero), .D(c_d),
      .EN(c_en), .CAI(c_one), .OVF_CLR(c_zero), .Q(lo_q), .CAO(lo_cao),
      .OVF(lo_ovf)
   );

   cbu_modn_counter #(.WIDTH(W), .MODULUS(M)) u_hi (
      .CLK(clk), .CDN(cdn), .CS(c_zero), .SP(c_zero), .LD(c_zero), .D(c_d),
      .EN(c_en), .CAI(lo_cao), .OVF_CLR(c_zero), .Q(hi_q), .CAO(hi_cao),
      .OVF(hi_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish (act=running exp=done)");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   typedef struct {
      logic         cs, sp, ld;
      logic [W-1:0] d;
      logic         en, cai, oc;
      logic         exp_cao;
      logic [W-1:0] exp_q;
      logic         exp_ovf;
      string        name;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input string name, input logic c, input logic s,
                               input logic l, input int dv, input logic e,
                               input logic ci, input logic oc, input logic xc,
                               input int xq, input logic xo);
      vec_t v;
      v.name = name; v.cs = c; v.sp = s; v.ld = l; v.d = W'(dv);
      v.en = e; v.cai = ci; v.oc = oc;
      v.exp_cao = xc; v.exp_q = W'(xq); v.exp_ovf = xo;
      vecs.push_back(v);
   endfunction

   initial begin
      cdn = 1'b0; cs = 0; sp = 0; ld = 0; d = '0; en = 0; cai = 0; ovf_clr = 0;
      c_en = 0; c_one = 1'b1; c_zero = 1'b0; c_d = '0;

      // ---------------- Test 1: reset and async clear ----------------
      @(negedge clk); @(negedge clk);
      cdn = 1'b1;
      #1 chk("reset_q", q, 0);
      chk("reset_ovf", ovf, 0);

      // Count 17 clocks: one full wrap sets OVF, and Q ends at 7.
      en = 1; cai = 1;
      repeat (17) @(posedge clk);
      #1 chk("pre_clr_q", q, 7);
      chk("pre_clr_ovf", ovf, 1);

      #2 cdn = 1'b0;            // asserted mid-cycle, away from any edge
      #1 chk("async_clr_q", q, 0);
      chk("async_clr_ovf", ovf, 0);
      @(posedge clk);
      #1 chk("clr_held_q", q, 0);
      @(negedge clk);
      cdn = 1'b1; en = 0; cai = 0;

      // ---------------- Vector table ----------------
      // Columns: name, CS, SP, LD, D, EN, CAI, OVF_CLR, exp CAO, exp Q, exp OVF
      for (int i = 0; i < 5; i++)
         add("hold", 0,0,0,0, 0,0,0, 0, 0, 0);
      add("hold_cai0", 0,0,0,0, 1,0,0, 0, 0, 0);
      add("hold_en0",  0,0,0,0, 0,1,0, 0, 0, 0);

      // Test 2: modulo counting 1..9 then 0
      for (int n = 1; n <= 10; n++)
         add("count", 0,0,0,0, 1,1,0, (n == 10), n % M, (n == 10));

      // Test 3: priority. CAO still reflects the terminal count when LD wins.
      add("prio_cs",   1,1,1,5, 1,1,0, 0, 0, 1);
      add("prio_sp",   0,1,1,5, 1,1,0, 0, 9, 1);
      add("prio_ld",   0,0,1,5, 1,1,0, 1, 5, 1);
      add("ovf_clr",   0,0,0,0, 0,0,1, 0, 5, 0);

      // Test 4: an out-of-range load recovers to 0 and sets OVF.
      add("ld_13",     0,0,1,13, 0,0,0, 0, 13, 0);
      add("cnt_13",    0,0,0,0,  1,1,0, 1, 0, 1);
      add("ld_15",     0,0,1,15, 0,0,0, 0, 15, 1);
      add("cnt_15",    0,0,0,0,  1,1,0, 1, 0, 1);

      // Test 5: set/clear collision
      add("clr2",      0,0,0,0, 0,0,1, 0, 0, 0);
      add("preset",    0,1,0,0, 0,0,0, 0, 9, 0);
      add("collide",   0,0,0,0, 1,1,1, 1, 0, 1);
      add("clr_nowrap",0,0,0,0, 1,1,1, 0, 1, 0);
      add("cs_alone",  1,0,0,0, 1,1,0, 0, 0, 0);

      foreach (vecs[i]) begin
         @(negedge clk);
         cs = vecs[i].cs; sp = vecs[i].sp; ld = vecs[i].ld; d = vecs[i].d;
         en = vecs[i].en; cai = vecs[i].cai; ovf_clr = vecs[i].oc;
         #1 chk({vecs[i].name, "_cao"}, cao, vecs[i].exp_cao);
         @(posedge clk);
         #1 chk({vecs[i].name, "_q"}, q, vecs[i].exp_q);
         chk({vecs[i].name, "_ovf"}, ovf, vecs[i].exp_ovf);
      end
      @(negedge clk);
      cs = 0; sp = 0; ld = 0; en = 0; cai = 0; ovf_clr = 0;

      // ---------------- Test 6: two-stage cascade ----------------
      // Both stages were cleared by the CDN pulse and have held since then.
      c_en = 1'b1;
      for (int n = 1; n <= 99; n++) begin
         @(posedge clk);
         #1 chk("casc_lo", lo_q, n % 10);
         chk("casc_hi", hi_q, n / 10);
      end
      chk("casc_hi_cao_99", hi_cao, 1);
      chk("casc_hi_ovf_99", hi_ovf, 0);
      @(posedge clk);
      #1 chk("casc_wrap_lo", lo_q, 0);
      chk("casc_wrap_hi", hi_q, 0);
      chk("casc_wrap_hi_ovf", hi_ovf, 1);
      chk("casc_wrap_lo_ovf", lo_ovf, 1);
      repeat (5) @(posedge clk);
      @(negedge clk);
      c_en = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("freeze_lo", lo_q, 5);
      chk("freeze_hi", hi_q, 0);
      chk("freeze_hi_cao", hi_cao, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cbu_modn_counter.md
Name: cbu_modn_counter

Overview:
- Parameterised synchronous up counter with modulo wrap and cascade carry in/out (CAI/CAO).
- Counts in the opposite direction to the team's 4-bit down counters and shares their cascade convention, so stages chain into multi-digit up counters such as BCD or timebase prescalers.
- Supports parallel load, synchronous clear, synchronous preset-to-terminal, and a sticky wrap flag.

Parameters:
- WIDTH, 4, counter width in bits (range 2..16).
- MODULUS, 16, count sequence length; Q runs 0..MODULUS-1 (range 2..2**WIDTH).

Ports:
- CLK  input  1  rising-edge clock
- CDN  input  1  asynchronous active-low clear; forces Q=0 and OVF=0
- CS  input  1  synchronous clear, active-high
- SP  input  1  synchronous preset to terminal value MODULUS-1, active-high
- LD  input  1  synchronous parallel load, active-high
- D  input  WIDTH  parallel load data
- EN  input  1  count enable
- CAI  input  1  cascade carry in; tie high on the least significant stage
- OVF_CLR  input  1  synchronous clear of OVF
- Q  output  WIDTH  current count
- CAO  output  1  cascade carry out (combinational)
- OVF  output  1  sticky wrap flag (registered)

Behaviour:
- Reset:
  - CDN=0 forces Q=0 and OVF=0 immediately, independent of CLK.
  - Both stay 0 while CDN is low.
  - The first rising CLK after CDN deasserts is a normal cycle.
- Synchronous priority on each rising CLK: CS > SP > LD > count > hold.
  - CS=1: Q<=0.
  - else SP=1: Q<=MODULUS-1.
  - else LD=1: Q<=D. A D value >= MODULUS loads unchanged.
  - else CAI=1 and EN=1:
    - if Q >= MODULUS-1, Q<=0 (wrap);
    - otherwise Q<=Q+1.
    - The Q >= test also recovers out-of-range loaded values to 0 on the next count.
  - else Q holds.
- CAO:
  - CAO = CAI & EN & (Q >= MODULUS-1).
  - Purely combinational; no latency.
  - Ignores CS, SP and LD, matching the down-counter cascade convention.
- OVF:
  - wrap_evt = (count branch taken) & (Q >= MODULUS-1).
  - wrap_evt=1: OVF<=1.
  - else OVF_CLR=1: OVF<=0.
  - else OVF holds.
  - If wrap_evt and OVF_CLR occur in the same cycle, set wins.
  - CS, SP and LD do not affect OVF; only CDN and OVF_CLR clear it.
- Arithmetic:
  - Unsigned, WIDTH bits.
  - When MODULUS = 2**WIDTH, wrap equals natural rollover from all-ones to 0.
  - No intermediate value beyond MODULUS-1 is ever produced by counting.
- Cascading:
  - Stage n CAI connects to stage n-1 CAO, and all stages share EN.
  - The upper stage advances in the same clock edge as the lower stage wraps.
- Mid-operation reset: CDN asserting at any point, including the cycle of a wrap or load, leaves Q=0 and OVF=0 with no partial update.

Test Plan:
1. Reset and hold: WIDTH=4, MODULUS=10. Pulse CDN low mid-count at Q=7 -> Q=0 and OVF=0 asynchronously. With CAI=EN=0 for 5 clocks, Q stays 0 and CAO=0.
2. Modulo counting: CAI=EN=1 from Q=0 for 10 clocks.
   - Q runs 1..9 then 0.
   - CAO=1 only while Q=9.
   - OVF rises on the clock where Q goes 9->0.
3. Priority: drive CS=1, SP=1, LD=1 with D=5 -> Q=0. SP=1, LD=1 -> Q=9. LD=1 alone with D=5 -> Q=5. Each case with CAI=EN=1, and no count occurs.
4. Out-of-range load: LD with D=13, then count one clock -> Q=0, OVF=1, and CAO=1 during the Q=13 cycle.
5. OVF set/clear collision: with Q=9 counting and OVF_CLR=1 -> OVF stays 1. The next cycle with OVF_CLR=1 and no wrap -> OVF=0.
6. Two-stage cascade, both MODULUS=10:
   - Count 99 clocks -> {hi,lo}=9,9, with hi CAO=1.
   - One more clock -> 0,0, and hi OVF=1.
   - Lo EN=0 freezes both stages.
